// File: rtl/alu_pipe_seq.sv
// alu_pipe_seq: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops load at accept; MUL iterates one multiplier bit per cycle.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, op captured at accept)
//   out_valid/out_ready result handshake (result, cout, zero, ovf held until taken)
//   busy                high while a multiply is iterating
module alu_pipe_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] ONE  = {{(SHW-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_SLTU = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic               w_is_mul;
    logic               w_load_alu;
    logic               w_start_mul;
    logic               w_load_mul;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [WIDTH-1:0]   w_res;
    logic               w_cout;
    logic               w_ovf;
    logic [2*WIDTH-1:0] w_acc_nxt;

    logic [SHW-1:0]     r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;

    // With MUL_EN = 0 the MUL code falls through to the undefined-op path.
    assign w_is_mul = MUL_EN && (op == OP_MUL);
    assign w_sh     = b[SHW-1:0];
    assign w_sum    = {1'b0, a} + {1'b0, b};
    assign w_dif    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (op)
            OP_ADD: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = (a[WIDTH-1] == b[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res  = w_dif[WIDTH-1:0];
                w_cout = w_dif[WIDTH];
                w_ovf  = (a[WIDTH-1] != b[WIDTH-1]) &&
                         (w_dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  w_res = a & b;
            OP_XOR:  w_res = a ^ b;
            OP_OR:   w_res = a | b;
            // True signed compare: immune to overflow of a - b.
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  w_res = a << w_sh;
            OP_SRL:  w_res = a >> w_sh;
            OP_SRA:  w_res = $unsigned($signed(a) >>> w_sh);
            default: w_res = '0;
        endcase
    end

    // One shift-add step: multiplicand shifts left, multiplier right.
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_load_alu  = 1'b0;
        w_start_mul = 1'b0;
        w_load_mul  = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load_alu  = !w_is_mul;
                    w_start_mul = w_is_mul;
                    w_state_nxt = w_is_mul ? S_MUL : S_HOLD;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (r_cnt == LAST) begin
                    w_load_mul  = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_load_alu  = !w_is_mul;
                        w_start_mul = w_is_mul;
                        w_state_nxt = w_is_mul ? S_MUL : S_HOLD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            cout     <= 1'b0;
            zero     <= 1'b0;
            ovf      <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
        end else begin
            if (w_load_alu) begin
                result <= w_res;
                cout   <= w_cout;
                ovf    <= w_ovf;
                zero   <= (w_res == '0);
            end
            if (w_start_mul) begin
                r_mcand  <= {{WIDTH{1'b0}}, a};
                r_mplier <= b;
                r_acc    <= '0;
                r_cnt    <= '0;
            end
            if (r_state == S_MUL) begin
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_acc    <= w_acc_nxt;
                r_cnt    <= r_cnt + ONE;
            end
            // Final step folds its partial product straight into the result.
            if (w_load_mul) begin
                result <= w_acc_nxt[WIDTH-1:0];
                cout   <= 1'b0;
                ovf    <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                zero   <= (w_acc_nxt[WIDTH-1:0] == '0);
                r_cnt  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe_seq.sv
// tb_alu_pipe_seq: directed and randomized checks of alu_pipe_seq
// against a latency/arithmetic reference model (WIDTH = 32).
module tb_alu_pipe_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        cout;
    logic        zero;
    logic        ovf;
    logic        busy;

    alu_pipe_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .zero(zero), .ovf(ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit        m_known  = 1'b0;
    bit        m_pend   = 1'b0;
    bit        m_rstchk = 1'b0;
    int        m_wait   = 0;
    bit [31:0] m_res    = '0;
    bit        m_cout   = 1'b0;
    bit        m_zero   = 1'b0;
    bit        m_ovf    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Returns {ovf, zero, cout, result} from plain 64-bit arithmetic.
    function automatic bit [34:0] ref_op(input bit [31:0] x,
                                         input bit [31:0] y,
                                         input bit [3:0] o);
        bit [63:0] w;
        longint    sx;
        longint    sy;
        longint    d;
        bit [31:0] r;
        bit        c;
        bit        v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        w = '0; d = 0; r = '0; c = 1'b0; v = 1'b0;
        case (o)
            4'h0: begin
                w = {32'b0, x} + {32'b0, y};
                r = w[31:0]; c = w[32];
                d = sx + sy;
                v = (d != longint'($signed(d[31:0])));
            end
            4'h1: begin
                w = {32'b0, x} + {32'b0, ~y} + 64'd1;
                r = w[31:0]; c = w[32];
                d = sx - sy;
                v = (d != longint'($signed(d[31:0])));
            end
            4'h2: r = x & y;
            4'h3: r = x ^ y;
            4'h4: r = x | y;
            4'h5: r = (sx < sy) ? 32'd1 : 32'd0;
            4'h6: r = (x < y) ? 32'd1 : 32'd0;
            4'h7: r = x << y[4:0];
            4'h8: r = x >> y[4:0];
            4'h9: r = 32'($signed(x) >>> y[4:0]);
            4'hA: begin
                w = 64'(x) * 64'(y);
                r = w[31:0];
                v = (w[63:32] != 32'd0);
            end
            default: r = '0;
        endcase
        return {v, (r == 32'd0), c, r};
    endfunction

    // Compare just after inputs settle, then advance the model on the edge.
    task automatic cycle();
        bit e_val;
        bit e_rdy;
        bit acc;
        bit xfer;
        #1;
        e_val = m_pend && (m_wait == 0);
        e_rdy = !m_pend || (e_val && out_ready);
        if (m_known) begin
            chk("in_ready", 32'(in_ready), 32'(e_rdy));
            chk("out_valid", 32'(out_valid), 32'(e_val));
            chk("busy", 32'(busy), 32'(m_pend && m_wait > 0));
            if (e_val) begin
                chk("result", result, m_res);
                chk("flags", 32'({cout, zero, ovf}),
                    32'({m_cout, m_zero, m_ovf}));
            end
            if (m_rstchk) begin
                chk("rst_result", result, 32'd0);
                chk("rst_flags", 32'({cout, zero, ovf}), 32'd0);
            end
        end
        @(posedge clk);
        m_rstchk = 1'b0;
        if (rst) begin
            m_known  = 1'b1;
            m_pend   = 1'b0;
            m_wait   = 0;
            m_rstchk = 1'b1;
        end else if (m_known) begin
            acc  = in_valid && e_rdy;
            xfer = e_val && out_ready;
            if (m_pend && m_wait > 0) m_wait--;
            if (xfer) m_pend = 1'b0;
            if (acc) begin
                {m_ovf, m_zero, m_cout, m_res} = ref_op(a, b, op);
                m_pend = 1'b1;
                m_wait = (op == 4'hA) ? 32 : 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        n = 0;
        while (m_pend && n < 60) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 32'(m_pend), 32'd0);
    endtask

    // ef = {cout, zero, ovf}; elat = cycles after the accept cycle.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic [3:0] iop, input logic [31:0] er,
                         input logic [2:0] ef, input int elat,
                         input string name);
        int n;
        drain();
        a = ia; b = ib; op = iop; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 4'($urandom_range(15));
        n = 0;
        while (!out_valid && n < 60) begin
            cycle();
            n++;
        end
        chk({name, "_lat"}, 32'(n), 32'(elat));
        chk({name, "_res"}, result, er);
        chk({name, "_flags"}, 32'({cout, zero, ovf}), 32'(ef));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(40));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_zero", 32'(zero), 32'd0);

        issue(32'hFFFF_FFFF, 32'h1, 4'h0, 32'h0, 3'b110, 0, "add_wrap");
        issue(32'h8000_0000, 32'h1, 4'h1, 32'h7FFF_FFFF, 3'b101, 0, "sub_ovf");
        issue(32'h7FFF_FFFF, 32'h8000_0000, 4'h5, 32'h0, 3'b010, 0, "slt_big");
        issue(32'hFFFF_FFFF, 32'h1, 4'h5, 32'h1, 3'b000, 0, "slt_neg");
        issue(32'hFFFF_FFFF, 32'h1, 4'h6, 32'h0, 3'b010, 0, "sltu");
        issue(32'h8000_0000, 32'h24, 4'h9, 32'hF800_0000, 3'b000, 0, "sra");
        issue(32'h0001_0000, 32'h0001_0000, 4'hA, 32'h0, 3'b011, 32, "mul_ovf");
        issue(32'd12345, 32'd678, 4'hA, 32'd8369910, 3'b000, 32, "mul");

        drain();
        out_ready = 1'b0;
        a = 32'd3; b = 32'd4; op = 4'h0; in_valid = 1'b1;
        cycle();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_result", result, 32'd7);
            cycle();
        end
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 4);
            a = 32'(i * 16); b = 32'd1; op = 4'h0;
            #1;
            if (out_valid) n++;
            cycle();
        end
        chk("stream_count", 32'(n), 32'd5);
        chk("stream_end", 32'(out_valid), 32'd0);

        drain();
        a = 32'h0001_2345; b = 32'h0000_FFFF; op = 4'hA; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (10) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mulrst_out_valid", 32'(out_valid), 32'd0);
        chk("mulrst_busy", 32'(busy), 32'd0);
        chk("mulrst_in_ready", 32'(in_ready), 32'd1);
        chk("mulrst_result", result, 32'd0);
        issue(32'h1234_5678, 32'h9ABC_DEF0, 4'hF, 32'h0, 3'b010, 0, "undef");

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(199) == 0);
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 7);
            op        = 4'($urandom_range(15));
            a         = pick();
            b         = pick();
            cycle();
        end
        rst = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
